// File: rtl/if_id_pipe_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a two-entry skid buffer.
// The MAIN entry drives the decode-facing outputs directly. The SKID entry catches
// one extra beat while decode stalls, so in_ready depends only on registered state.
// A flush empties the stage, presents NOP_INST and counts the discarded entries in a
// saturating counter.
module if_id_pipe_skid_reg #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       PC_W     = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_r,     state_nx_s;
  logic [INST_W-1:0] main_inst_r, main_inst_nx_s;
  logic [PC_W-1:0]   main_pc_r,   main_pc_nx_s;
  logic [INST_W-1:0] skid_inst_r, skid_inst_nx_s;
  logic [PC_W-1:0]   skid_pc_r,   skid_pc_nx_s;
  logic              out_valid_r;
  logic              in_ready_r;
  logic [CNT_W-1:0]  squash_cnt_r, squash_cnt_nx_s;
  logic [1:0]        squash_add_s;
  logic [CNT_W:0]    cnt_sum_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  assign out_valid  = out_valid_r;
  assign in_ready   = in_ready_r;
  assign inst_out   = main_inst_r;
  assign pc_out     = main_pc_r;
  assign squash_cnt = squash_cnt_r;

  // Next-state and datapath selection; flush overrides every handshake outcome.
  always_comb begin
    state_nx_s     = state_r;
    main_inst_nx_s = main_inst_r;
    main_pc_nx_s   = main_pc_r;
    skid_inst_nx_s = skid_inst_r;
    skid_pc_nx_s   = skid_pc_r;
    if (flush) begin
      state_nx_s     = ST_EMPTY;
      main_inst_nx_s = NOP_INST;
      main_pc_nx_s   = pc_in;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nx_s     = ST_ONE;
            main_inst_nx_s = inst_in;
            main_pc_nx_s   = pc_in;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_inst_nx_s = inst_in;
            main_pc_nx_s   = pc_in;
          end else if (in_fire_s) begin
            // Decode stalled: the younger beat parks in SKID behind MAIN.
            state_nx_s     = ST_TWO;
            skid_inst_nx_s = inst_in;
            skid_pc_nx_s   = pc_in;
          end else if (out_fire_s) begin
            // Drained: show a bubble but keep the last PC visible.
            state_nx_s     = ST_EMPTY;
            main_inst_nx_s = NOP_INST;
          end else begin
            state_nx_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_nx_s     = ST_ONE;
            main_inst_nx_s = skid_inst_r;
            main_pc_nx_s   = skid_pc_r;
          end else begin
            state_nx_s = ST_TWO;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean empty stage.
          state_nx_s     = ST_EMPTY;
          main_inst_nx_s = NOP_INST;
        end
      endcase
    end
  end

  // Number of held entries discarded by a flush; a MAIN handed to decode on the same edge is not counted.
  always_comb begin
    squash_add_s = 2'd0;
    if (flush) begin
      case (state_r)
        ST_ONE:  squash_add_s = out_fire_s ? 2'd0 : 2'd1;
        ST_TWO:  squash_add_s = out_fire_s ? 2'd1 : 2'd2;
        default: squash_add_s = 2'd0;
      endcase
    end else begin
      squash_add_s = 2'd0;
    end
  end

  // Saturating add: the extra sum bit signals overflow, which pins the counter at all-ones.
  always_comb begin
    cnt_sum_s = {1'b0, squash_cnt_r} + (CNT_W+1)'(squash_add_s);
    if (cnt_sum_s[CNT_W]) begin
      squash_cnt_nx_s = {CNT_W{1'b1}};
    end else begin
      squash_cnt_nx_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // State, entry storage and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      main_inst_r  <= NOP_INST;
      main_pc_r    <= {PC_W{1'b0}};
      skid_inst_r  <= {INST_W{1'b0}};
      skid_pc_r    <= {PC_W{1'b0}};
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
      squash_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      main_inst_r  <= main_inst_nx_s;
      main_pc_r    <= main_pc_nx_s;
      skid_inst_r  <= skid_inst_nx_s;
      skid_pc_r    <= skid_pc_nx_s;
      out_valid_r  <= (state_nx_s != ST_EMPTY);
      in_ready_r   <= (state_nx_s != ST_TWO);
      squash_cnt_r <= squash_cnt_nx_s;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_skid_reg.sv
// Directed bench for if_id_pipe_skid_reg. The driver pushes each beat it expects the
// stage to accept into a scoreboard. The negedge monitor pops one beat per delivered
// output and checks the squash counters of a 16-bit and a 2-bit counter instance.
module tb_if_id_pipe_skid_reg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] inst_in = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready,  out_valid;
  logic [31:0] inst_out,  pc_out;
  logic [15:0] squash_cnt;
  logic        in_ready_s, out_valid_s;
  logic [31:0] inst_out_s, pc_out_s;
  logic [1:0]  squash_cnt_s;

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_cnt = 0;

  if_id_pipe_skid_reg #(.INST_W(32), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .inst_out(inst_out), .pc_out(pc_out), .squash_cnt(squash_cnt)
  );

  if_id_pipe_skid_reg #(.INST_W(32), .PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .inst_in(inst_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid_s),
    .out_ready(out_ready), .inst_out(inst_out_s), .pc_out(pc_out_s), .squash_cnt(squash_cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, entered and left at posedge+1. rdy is the hand-computed
  // in_ready, sq the hand-computed number of entries squashed by a flush.
  task automatic b(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                   input logic ordy, input logic fl, input logic rdy, input int sq);
    in_valid  = v;
    inst_in   = inst;
    pc_in     = pc;
    out_ready = ordy;
    flush     = fl;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (v && rdy && !fl) sb_q.push_back('{inst: inst, pc: pc});
    @(posedge clk);
    #1;
    if (fl) begin
      sb_q.delete();
      exp_cnt += sq;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_inst_out", 64'(inst_out), 64'd0);
      chk("flush_pc_out", 64'(pc_out), 64'(pc));
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_inst_out", 64'(inst_out), 64'd0);
    chk("rst_pc_out", 64'(pc_out), 64'd0);
    chk("rst_squash_cnt", 64'(squash_cnt), 64'd0);
    chk("rst_squash_cnt_sat", 64'(squash_cnt_s), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every delivered beat and tracks the squash counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_ready) begin
          chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            beat_t e;
            e = sb_q.pop_front();
            chk("out_inst", 64'(inst_out), 64'(e.inst));
            chk("out_pc", 64'(pc_out), 64'(e.pc));
          end
        end
      end else begin
        chk("idle_inst_nop", 64'(inst_out), 64'd0);
      end
      chk("squash_cnt", 64'(squash_cnt), 64'(exp_cnt));
      chk("squash_cnt_sat", 64'(squash_cnt_s), 64'((exp_cnt > 3) ? 3 : exp_cnt));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;

    // Reset asserted mid-cycle with one entry held: outputs clear immediately.
    b(1'b1, 32'h55, 32'h100, 1'b0, 1'b0, 1'b1, 0);
    #2 rst = 1'b1;
    #1 chk_reset();
    sb_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming with decode always ready.
    for (int i = 0; i < 5; i++) b(1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b1, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    chk("drain_pc_hold", 64'(pc_out), 64'h10);

    // Stall fills the skid entry, a third offer is refused, release drains in order.
    b(1'b1, 32'h11, 32'h44, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h22, 32'h48, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h99, 32'h4C, 1'b0, 1'b0, 1'b0, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);

    // Flush while full and stalled: both entries squashed, offered beat dropped.
    b(1'b1, 32'h31, 32'h60, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h32, 32'h64, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h33, 32'h68, 1'b0, 1'b1, 1'b0, 2);

    // Flush while empty: the offered beat is dropped even though in_ready is high.
    b(1'b1, 32'h34, 32'h6C, 1'b1, 1'b1, 1'b1, 0);

    // Flush in ONE with decode ready: MAIN is delivered, nothing squashed.
    b(1'b1, 32'h41, 32'h70, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h42, 32'h74, 1'b1, 1'b1, 1'b1, 0);

    // Flush in ONE while stalled: one entry squashed.
    b(1'b1, 32'h43, 32'h78, 1'b0, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'h7C, 1'b0, 1'b1, 1'b1, 1);

    // Repeated flushes in TWO drive the 2-bit counter into saturation.
    for (int k = 0; k < 4; k++) begin
      b(1'b1, 32'h50 + 32'(2 * k), 32'h80 + 32'(8 * k), 1'b0, 1'b0, 1'b1, 0);
      b(1'b1, 32'h51 + 32'(2 * k), 32'h84 + 32'(8 * k), 1'b0, 1'b0, 1'b1, 0);
      b(1'b0, 32'h0, 32'h90, 1'b0, 1'b1, 1'b0, 2);
    end

    // Flush in TWO with decode ready: MAIN delivered, SKID squashed.
    b(1'b1, 32'h61, 32'hA0, 1'b0, 1'b0, 1'b1, 0);
    b(1'b1, 32'h62, 32'hA4, 1'b0, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'hA8, 1'b1, 1'b1, 1'b0, 1);

    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    b(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
    chk("final_cnt", 64'(squash_cnt), 64'd12);
    chk("final_cnt_sat", 64'(squash_cnt_s), 64'd3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
